keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad: drives active-low columns, samples active-low rows, debounces, and decodes one hex digit per press.
- Digits are assembled into an 8-bit two-digit entry value that feeds the register-file/PC data input of the experiment top level.
- Also provides a one-cycle strobe per accepted key.
- Sits between the board keypad pins and the datapath's DATA_INPUT.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column dwell time); must be >= 2
DEBOUNCE_TICKS, 4, consecutive matching scan ticks needed to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
clr  input  1  synchronous active-high reset
KEY_R  input  4  row sense lines, active low; KEY_R[r]=0 means a key in row r is closed on the driven column
KEY_C  output  4  column drive, active low, exactly one bit low at all times
out  output  8  entry value; {previous digit, latest digit}
key_code  output  4  code of the most recently accepted key
key_valid  output  1  one-cycle pulse per accepted key
key_held  output  1  high while an accepted key has not yet been released (state HELD)

Behaviour:
- Reset: on a clk edge with clr=1:
  - KEY_C=4'b1110 (column 0); out=8'h00; key_code=4'h0; key_valid=0; key_held=0.
  - Divider and debounce counter cleared; state SCAN.
  - clr overrides all other activity, including a key mid-debounce or held.
- Tick: divider counts 0..SCAN_DIV-1 and wraps. "Tick" means the edge on which the divider equals SCAN_DIV-1. All FSM decisions happen only on ticks.
- Column index c: the position of the low bit in KEY_C. Rotation order is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Valid press pattern: exactly one KEY_R bit low. Row index r is that bit. Zero or two or more low bits mean "no key".
- Decode: code = {r[1:0], c[1:0]}, i.e. 4*r + c.
- FSM:
  - SCAN:
    - Valid pattern on tick: latch r, c and the pattern; clear the debounce count; go to DEBOUNCE. KEY_C is not rotated.
    - Otherwise: rotate KEY_C.
  - DEBOUNCE: KEY_C is held.
    - On each tick where KEY_R equals the latched pattern, increment the count.
    - When the count reaches DEBOUNCE_TICKS:
      - key_code <= code; out <= {out[3:0], code}; key_valid <= 1 for exactly one cycle.
      - key_held <= 1; clear the count; go to HELD.
    - On any tick where KEY_R differs from the latched pattern: clear the count, rotate KEY_C, go to SCAN. No strobe, no out change.
  - HELD: KEY_C is held; no auto-repeat.
    - On each tick with KEY_R==4'hF, increment the count.
    - On a tick with any row low, clear the count.
    - When the count reaches DEBOUNCE_TICKS: key_held <= 0; clear the count; rotate KEY_C; go to SCAN.
- Latency: key_valid rises on the edge of the DEBOUNCE_TICKS-th matching tick after the detection tick. It falls on the next edge. out and key_code update on that same edge and then hold.
- key_valid never asserts twice for one physical press, and never asserts outside the DEBOUNCE->HELD transition.
- out only shifts; it is cleared only by clr.
- KEY_R is treated as synchronous to clk; board-level synchronisers sit outside this block.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
1. Assert clr for 2 cycles, KEY_R=4'hF -> KEY_C=4'b1110, out=8'h00, key_valid=0, key_held=0. Then KEY_C rotates every 4 cycles through 1101, 1011, 0111, 1110.
2. Hold key row1/col2 (KEY_R=4'b1101 whenever KEY_C=4'b1011) -> detected on the col2 tick. Exactly 3 ticks (12 cycles) later: single key_valid pulse, key_code=4'h6, out=8'h06, key_held=1. KEY_C stays 1011 while the key is held.
3. Release for 3 ticks, then press row2/col2 -> key_held falls after 3 released ticks and scanning resumes. Second press gives key_code=4'hA, out=8'h6A. A third press of row0/col1 gives out=8'hA1.
4. Bounce: row1/col2 low for 2 ticks, then KEY_R=4'hF -> no key_valid, out unchanged, KEY_C rotates to 0111 on the mismatch tick.
5. KEY_R=4'b1100 (two rows low) on any column -> treated as no key: scanning continues, no strobe. Release chatter in HELD (high 2 ticks, low 1 tick, high 3 ticks) -> key_held drops only after the final 3 high ticks, with no second key_valid.
6. Assert clr while in HELD with the key still pressed -> immediate reset values (out=8'h00). The still-pressed key is then rescanned and accepted once again after its column tick plus 3 ticks (out=8'h0<code>).

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and two-digit hex entry.
// One column is driven low per scan tick; presses shift into out.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] KEY_R,
  output logic [3:0] KEY_C,
  output logic [7:0] out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    col, col_n;
  logic [1:0]    row, row_n;
  logic [3:0]    pat, pat_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0]    out_n;
  logic [3:0]    code_n;
  logic          valid_n, held_n;
  logic          one_hot;
  logic [1:0]    row_dec;

  assign tick    = (div == DIV_MAX);
  assign cnt_inc = cnt + 1'b1;
  assign KEY_C   = ~(4'b0001 << col);

  // Scan-rate divider; wraps on the tick edge.
  always_ff @(posedge clk) begin
    if (clr || tick) div <= '0;
    else             div <= div + 1'b1;
  end

  // Row sense decode: exactly one low row is a key, anything else is none.
  always_comb begin
    one_hot = 1'b1;
    row_dec = 2'd0;
    unique case (KEY_R)
      4'b1110: row_dec = 2'd0;
      4'b1101: row_dec = 2'd1;
      4'b1011: row_dec = 2'd2;
      4'b0111: row_dec = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      pat       <= 4'hF;
      cnt       <= '0;
      out       <= 8'h00;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      pat       <= pat_n;
      cnt       <= cnt_n;
      out       <= out_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  // Next-state logic; every decision waits for a scan tick.
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    pat_n   = pat;
    cnt_n   = cnt;
    out_n   = out;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_hot) begin
            row_n   = row_dec;
            pat_n   = KEY_R;
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (KEY_R == pat) begin
            if (cnt_inc == CNT_MAX) begin
              code_n  = {row, col};
              out_n   = {out[3:0], row, col};
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            col_n   = col + 2'd1;
            state_n = SCAN;
          end
        end
        HELD: begin
          if (KEY_R == 4'hF) begin
            if (cnt_inc == CNT_MAX) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              col_n   = col + 2'd1;
              state_n = SCAN;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, strobe scoreboard,
// and directed timing checks with SCAN_DIV=4, DEBOUNCE_TICKS=3.
module tb_keypad_scanner;

  logic       clk;
  logic       clr;
  logic [3:0] KEY_R;
  logic [3:0] KEY_C;
  logic [7:0] out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       press;
  logic [1:0] pr, pc;
  logic       force_en;
  logic [3:0] force_r;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .KEY_R(KEY_R),
    .KEY_C(KEY_C),
    .out(out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low only while its column is driven.
  assign KEY_R = force_en ? force_r :
                 (press && (KEY_C[pc] == 1'b0)) ? ~(4'b0001 << pr) : 4'hF;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (4 * n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [1:0] r, input logic [1:0] c);
    pr    = r;
    pc    = c;
    press = 1'b1;
  endtask

  task automatic expect_key(input logic [3:0] code, input logic [7:0] o);
    exp_q.push_back({code, o});
  endtask

  task automatic wait_valid(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (key_valid) break;
    end
    if (!key_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: no key_valid within %0d cycles", name, n);
    end else begin
      chk(name, 8'(n), 8'(exp_cycles));
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected key_valid code=%h out=%h",
                 key_code, out);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({key_code, out} !== e) begin
          errors++;
          $display("FAIL strobe: got code=%h out=%h expected code=%h out=%h",
                   key_code, out, e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    clr      = 1'b1;
    press    = 1'b0;
    pr       = 2'd0;
    pc       = 2'd0;
    force_en = 1'b0;
    force_r  = 4'hF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_keyc", {4'h0, KEY_C}, 8'h0E);
    chk("rst_out", out, 8'h00);
    chk("rst_valid", {7'd0, key_valid}, 8'h00);
    chk("rst_held", {7'd0, key_held}, 8'h00);
    chk("rst_code", {4'h0, key_code}, 8'h00);
    clr = 1'b0;

    tick(1); chk("rot1", {4'h0, KEY_C}, 8'h0D);
    tick(1); chk("rot2", {4'h0, KEY_C}, 8'h0B);
    tick(1); chk("rot3", {4'h0, KEY_C}, 8'h07);
    tick(1); chk("rot0", {4'h0, KEY_C}, 8'h0E);

    set_key(2'd1, 2'd2);
    expect_key(4'h6, 8'h06);
    wait_valid("lat_k6", 24);
    chk("held_k6", {7'd0, key_held}, 8'h01);
    tick(2);
    chk("hold_keyc", {4'h0, KEY_C}, 8'h0B);
    chk("hold_held", {7'd0, key_held}, 8'h01);
    press = 1'b0;
    tick(2);
    chk("rel2_held", {7'd0, key_held}, 8'h01);
    tick(1);
    chk("rel3_held", {7'd0, key_held}, 8'h00);
    chk("rel3_keyc", {4'h0, KEY_C}, 8'h07);

    set_key(2'd2, 2'd2);
    expect_key(4'hA, 8'h6A);
    wait_valid("lat_kA", 28);
    press = 1'b0;
    tick(3);
    chk("relA_held", {7'd0, key_held}, 8'h00);

    set_key(2'd0, 2'd1);
    expect_key(4'h1, 8'hA1);
    wait_valid("lat_k1", 24);
    press = 1'b0;
    tick(3);
    chk("rel1_keyc", {4'h0, KEY_C}, 8'h0B);

    set_key(2'd1, 2'd2);
    tick(2);
    chk("bnc_keyc", {4'h0, KEY_C}, 8'h0B);
    press = 1'b0;
    tick(1);
    chk("bnc_rot", {4'h0, KEY_C}, 8'h07);
    chk("bnc_out", out, 8'hA1);
    chk("bnc_held", {7'd0, key_held}, 8'h00);

    force_en = 1'b1;
    force_r  = 4'b1100;
    tick(5);
    chk("dbl_keyc", {4'h0, KEY_C}, 8'h0E);
    chk("dbl_out", out, 8'hA1);
    force_en = 1'b0;

    set_key(2'd3, 2'd0);
    expect_key(4'hC, 8'h1C);
    wait_valid("lat_kC", 16);
    press = 1'b0;
    tick(2);
    press = 1'b1;
    tick(1);
    press = 1'b0;
    tick(2);
    chk("chat_held", {7'd0, key_held}, 8'h01);
    tick(1);
    chk("chat_rel", {7'd0, key_held}, 8'h00);
    chk("chat_keyc", {4'h0, KEY_C}, 8'h0D);

    set_key(2'd2, 2'd3);
    expect_key(4'hB, 8'hCB);
    wait_valid("lat_kB", 24);
    tick(1);
    chk("pre_clr_held", {7'd0, key_held}, 8'h01);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_out", out, 8'h00);
    chk("clr_keyc", {4'h0, KEY_C}, 8'h0E);
    chk("clr_held", {7'd0, key_held}, 8'h00);
    chk("clr_code", {4'h0, key_code}, 8'h00);
    clr = 1'b0;
    expect_key(4'hB, 8'h0B);
    wait_valid("lat_kB2", 28);
    chk("final_out", out, 8'h0B);
    press = 1'b0;
    tick(4);

    chk("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
